booth_digit_sequencer: RTL and testbench
========================================

BOOTH_DIGIT_SEQUENCER -- requirements
Module: booth_digit_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default mul_pkg::WIDTH: multiplier operand width in bits, at least 2.
REQ-002 SHALL have parameter DIGIT_BITS, default 4: bits consumed per digit (4 = radix-16), range 2 to 8.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: an operand can be accepted this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: multiplier operand.
REQ-008 SHALL have port in_signed, input, 1 bit: 1 = two's-complement operand, 0 = unsigned; sampled with in_data.
REQ-009 SHALL have port flush, input, 1 bit: synchronous abort of the current operand.
REQ-010 SHALL have port out_valid, output, 1 bit: a digit is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the digit.
REQ-012 SHALL have port out_window, output, DIGIT_BITS+1 bits: {current group, previous group MSB}.
REQ-013 SHALL have port out_digit, output, DIGIT_BITS+1 bits, signed: decoded Booth digit.
REQ-014 SHALL have port out_idx, output, $clog2(MAXD) bits: digit index from 0, where MAXD = ceil((WIDTH+1)/DIGIT_BITS).
REQ-015 SHALL have port out_last, output, 1 bit: the presented digit is the final digit of the operand.

Function
REQ-016 Digit count SHALL be ND = ceil(WIDTH/DIGIT_BITS) for signed operands and ND = ceil((WIDTH+1)/DIGIT_BITS) for unsigned operands.
REQ-017 On load, the operand SHALL be extended to MAXD*DIGIT_BITS bits: sign-extended when signed, zero-extended when unsigned. The previous-bit register SHALL be cleared, the index SHALL be 0, and ND SHALL be latched.
REQ-018 The FSM SHALL have two states. In IDLE, in_ready=1 and out_valid=0; in_valid loads the operand and moves to SHIFT.
REQ-019 In SHIFT, out_valid=1 and out_window = {reg[DIGIT_BITS-1:0], prev}.
REQ-020 out_digit SHALL equal -2^(DIGIT_BITS-1)*w[DIGIT_BITS] + sum over i from 1 to DIGIT_BITS-1 of 2^(i-1)*w[i] + w[0], where w = out_window; range is ±2^(DIGIT_BITS-1).
REQ-021 A digit SHALL be transferred only when out_valid and out_ready are both 1.
REQ-022 On each transfer, prev SHALL take reg[DIGIT_BITS-1], reg SHALL shift right by DIGIT_BITS with sign or zero fill, and the index SHALL increment.
REQ-023 out_last SHALL be 1 when out_idx = ND-1. A transfer with out_last=1 SHALL end the operand.
REQ-024 Back-to-back operation: in SHIFT, in_ready SHALL equal out_ready AND out_last.
- If in_valid is also 1 in that cycle, the new operand SHALL load and the FSM SHALL stay in SHIFT with no bubble.
- Otherwise the FSM SHALL go to IDLE.
REQ-025 While out_valid=1 and out_ready=0, out_window, out_digit, out_idx and out_last SHALL hold stable.
REQ-026 flush=1 SHALL force IDLE on the next edge and discard the current digit.
- flush SHALL take priority over a transfer in the same cycle.
- During the flush cycle in_ready SHALL be 0, so a simultaneous in_valid is not accepted.
REQ-027 Latency: the first digit SHALL be valid in the cycle after the load handshake. With out_ready held at 1, one digit SHALL be transferred per cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force:
- state IDLE, so in_ready=1 and out_valid=0;
- shift register, prev bit, index, latched ND and latched signed mode all to 0.
REQ-029 An operand in progress when reset asserts SHALL be lost. No digit SHALL be presented until a new load.

Structure
REQ-030 mul_pkg SHALL hold:
- the WIDTH and DIGIT_BITS defaults;
- the state enum (IDLE, SHIFT);
- a function returning ND for (width, digit_bits, signed).
REQ-031 Window-to-digit decoding SHALL be a combinational sub-module named booth_digit_decode, parameterised by DIGIT_BITS.

Verification (WIDTH=8, DIGIT_BITS=4)
REQ-032 Signed load 0x96 (-106), out_ready held 1 -> two digits:
- idx0: window 01100, digit +6, out_last 0;
- idx1: window 10010, digit -7, out_last 1.
REQ-033 Unsigned load 0x96 (150), out_ready held 1 -> three digits:
- digits +6, -7, +1, with idx1 window 10010 and idx2 window 00001;
- out_last only at idx2;
- check: 256 - 112 + 6 = 150.
REQ-034 Back-to-back: signed 0x96, then in_valid held with signed 0x7F during the last transfer -> zero idle cycles; second operand gives digits -1 (window 11110), then +8 (window 01111).
REQ-035 Backpressure: out_ready=0 for 3 cycles at idx1 of signed 0x96 -> window 10010 and digit -7 held stable; in_ready stays 0.
REQ-036 Flush at idx1 with in_valid=1 in the same cycle -> no transfer, operand not accepted; next cycle IDLE with in_ready=1 and out_valid=0.
REQ-037 rst_n pulsed low mid-operand -> out_valid=0 and in_ready=1 immediately; a new signed 0x01 afterwards yields +1, then 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared parameters, FSM state encoding and digit-count helper for the
// Booth digit sequencer.
package mul_pkg;

    localparam int WIDTH      = 8;
    localparam int DIGIT_BITS = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // An unsigned operand needs one extra (zero) bit so its top digit stays non-negative.
    function automatic int nd_count(input int width, input int digit_bits, input logic is_signed);
        int bits_s;
        if (is_signed) begin
            bits_s = width;
        end else begin
            bits_s = width + 1;
        end
        return (bits_s + digit_bits - 1) / digit_bits;
    endfunction

endpackage

// File: rtl/booth_digit_decode.sv
// Combinational Booth window decoder: {group, previous MSB} -> signed digit.
module booth_digit_decode
    import mul_pkg::*;
#(
    parameter int DIGIT_BITS = mul_pkg::DIGIT_BITS
) (
    input  logic        [DIGIT_BITS:0] window,
    output logic signed [DIGIT_BITS:0] digit
);

    // Upper DIGIT_BITS bits read as two's complement, plus the borrowed previous bit.
    always_comb begin
        digit = $signed({window[DIGIT_BITS], window[DIGIT_BITS:1]})
              + $signed({{DIGIT_BITS{1'b0}}, window[0]});
    end

endmodule

// File: rtl/booth_digit_sequencer.sv
// Streams a multiplier operand out as radix-2^DIGIT_BITS Booth digits with
// valid/ready handshakes on both sides.
module booth_digit_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH      = mul_pkg::WIDTH,
    parameter int DIGIT_BITS = mul_pkg::DIGIT_BITS,
    localparam int MAXD      = (WIDTH + DIGIT_BITS) / DIGIT_BITS,
    localparam int IDXW      = (MAXD > 1) ? $clog2(MAXD) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic        [WIDTH-1:0]    in_data,
    input  logic                       in_signed,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [DIGIT_BITS:0] out_window,
    output logic signed [DIGIT_BITS:0] out_digit,
    output logic        [IDXW-1:0]     out_idx,
    output logic                       out_last
);

    localparam int EXTW = MAXD * DIGIT_BITS;
    localparam int NDW  = IDXW + 1;
    localparam logic [NDW-1:0] ND_SIGNED   = NDW'(nd_count(WIDTH, DIGIT_BITS, 1'b1));
    localparam logic [NDW-1:0] ND_UNSIGNED = NDW'(nd_count(WIDTH, DIGIT_BITS, 1'b0));

    state_e          state_q, state_d;
    logic [EXTW-1:0] sreg_q, sreg_d;
    logic            prev_q, prev_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [NDW-1:0]  nd_q, nd_d;
    logic            signed_q, signed_d;

    logic              last_s;
    logic              load_s;
    logic [EXTW-1:0]   ext_s;
    logic [2*EXTW-1:0] fill_s;
    logic [EXTW-1:0]   shifted_s;

    // Operand extension on load and sign/zero-filled right shift per digit.
    always_comb begin
        ext_s     = {{(EXTW-WIDTH){in_signed & in_data[WIDTH-1]}}, in_data};
        fill_s    = {{EXTW{signed_q & sreg_q[EXTW-1]}}, sreg_q};
        shifted_s = fill_s[DIGIT_BITS +: EXTW];
        last_s    = ({1'b0, idx_q} == (nd_q - NDW'(1)));
    end

    // Next-state and handshake logic; flush overrides any transfer or load.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        prev_d    = prev_q;
        idx_d     = idx_q;
        nd_d      = nd_q;
        signed_d  = signed_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_s    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~flush;
                if (in_valid && !flush) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                in_ready  = out_ready & last_s & ~flush;
                if (flush) begin
                    state_d = IDLE;
                end else if (out_ready && last_s) begin
                    if (in_valid) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (out_ready) begin
                    prev_d = sreg_q[DIGIT_BITS-1];
                    sreg_d = shifted_s;
                    idx_d  = idx_q + IDXW'(1);
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_s) begin
            state_d  = SHIFT;
            sreg_d   = ext_s;
            prev_d   = 1'b0;
            idx_d    = '0;
            nd_d     = in_signed ? ND_SIGNED : ND_UNSIGNED;
            signed_d = in_signed;
        end else begin
            signed_d = signed_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            prev_q   <= 1'b0;
            idx_q    <= '0;
            nd_q     <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            prev_q   <= prev_d;
            idx_q    <= idx_d;
            nd_q     <= nd_d;
            signed_q <= signed_d;
        end
    end

    // Presented digit fields come straight from the held registers, so they stay stable under backpressure.
    always_comb begin
        out_window = {sreg_q[DIGIT_BITS-1:0], prev_q};
        out_idx    = idx_q;
        out_last   = (state_q == SHIFT) & last_s;
    end

    booth_digit_decode #(
        .DIGIT_BITS (DIGIT_BITS)
    ) u_decode (
        .window (out_window),
        .digit  (out_digit)
    );

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// Directed self-checking bench for booth_digit_sequencer (WIDTH=8, DIGIT_BITS=4).
module tb_booth_digit_sequencer;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_signed;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_window;
    logic signed [4:0] out_digit;
    logic [1:0]        out_idx;
    logic              out_last;

    int tests_run;
    int tests_failed;

    booth_digit_sequencer #(
        .WIDTH      (8),
        .DIGIT_BITS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_signed  (in_signed),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_digit  (out_digit),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {out_valid, window, digit, idx, last} for compact comparisons.
    function automatic logic [13:0] obs();
        return {out_valid, out_window, out_digit, out_idx, out_last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_signed = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #3;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_state: got in_ready/out_valid=%b expected 10", {in_ready, out_valid});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_signed();
        in_valid = 1'b1; in_data = 8'h96; in_signed = 1'b1; out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL signed_load_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (obs() !== {1'b1, 5'b01100, 5'b00110, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL signed_idx0: got %b expected %b", obs(), {1'b1, 5'b01100, 5'b00110, 2'd0, 1'b0});
        end
        tick();
        tests_run++;
        if (obs() !== {1'b1, 5'b10010, 5'b11001, 2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL signed_idx1: got %b expected %b", obs(), {1'b1, 5'b10010, 5'b11001, 2'd1, 1'b1});
        end
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL signed_end_idle: got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_unsigned();
        in_valid = 1'b1; in_data = 8'h96; in_signed = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (obs() !== {1'b1, 5'b01100, 5'b00110, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL unsigned_idx0: got %b expected %b", obs(), {1'b1, 5'b01100, 5'b00110, 2'd0, 1'b0});
        end
        tick();
        tests_run++;
        if (obs() !== {1'b1, 5'b10010, 5'b11001, 2'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL unsigned_idx1: got %b expected %b", obs(), {1'b1, 5'b10010, 5'b11001, 2'd1, 1'b0});
        end
        tick();
        tests_run++;
        if (obs() !== {1'b1, 5'b00001, 5'b00001, 2'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL unsigned_idx2: got %b expected %b", obs(), {1'b1, 5'b00001, 5'b00001, 2'd2, 1'b1});
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL unsigned_end_idle: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 8'h96; in_signed = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h7F; in_signed = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_last, out_idx} !== {1'b1, 1'b1, 2'd1}) begin
            tests_failed++;
            $display("FAIL b2b_handover: got ready/last/idx=%b expected 1101", {in_ready, out_last, out_idx});
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (obs() !== {1'b1, 5'b11110, 5'b11111, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_idx0: got %b expected %b", obs(), {1'b1, 5'b11110, 5'b11111, 2'd0, 1'b0});
        end
        tick();
        tests_run++;
        if (obs() !== {1'b1, 5'b01111, 5'b01000, 2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_idx1: got %b expected %b", obs(), {1'b1, 5'b01111, 5'b01000, 2'd1, 1'b1});
        end
        tick();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 8'h96; in_signed = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({obs(), in_ready} !== {1'b1, 5'b10010, 5'b11001, 2'd1, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got %b expected %b", i, {obs(), in_ready},
                         {1'b1, 5'b10010, 5'b11001, 2'd1, 1'b1, 1'b0});
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL backpressure_release: got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 8'h96; in_signed = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        #1;
        tests_run++;
        if ({in_ready, out_idx} !== {1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL flush_ready: got ready/idx=%b expected 001", {in_ready, out_idx});
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL flush_idle: got %b expected 10", {in_ready, out_valid});
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_accept: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'h96; in_signed = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %b expected 10", {in_ready, out_valid});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_lost: got out_valid=%b expected 0", out_valid);
        end
        in_valid = 1'b1; in_data = 8'h01; in_signed = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (obs() !== {1'b1, 5'b00010, 5'b00001, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_new_idx0: got %b expected %b", obs(), {1'b1, 5'b00010, 5'b00001, 2'd0, 1'b0});
        end
        tick();
        tests_run++;
        if (obs() !== {1'b1, 5'b00000, 5'b00000, 2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_new_idx1: got %b expected %b", obs(), {1'b1, 5'b00000, 5'b00000, 2'd1, 1'b1});
        end
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_signed();
        test_unsigned();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
